// File: rtl/soc_system_lcd_pkg.sv
// -----------------------------------------------------------------------------
// soc_system_lcd_pkg
// Shared types and constants for the 8080-style LCD bus controller:
//   - FSM state encoding
//   - Avalon-MM register word offsets
//   - TIMING register layout and reset value
//   - command FIFO entry layout {rd, rs, data[15:0]}
//   - STATUS word packing helper
// -----------------------------------------------------------------------------
package soc_system_lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } lcd_state_e;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CMD    = 3'd1;
  localparam logic [2:0] ADDR_RDREQ  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_TIMING = 3'd4;
  localparam logic [2:0] ADDR_IRQ    = 3'd5;

  // Each field is a phase length minus one.
  typedef struct packed {
    logic [3:0] t_h;
    logic [3:0] t_pw;
    logic [3:0] t_su;
  } lcd_timing_t;

  localparam lcd_timing_t TIMING_RESET = 12'h121;

  typedef struct packed {
    logic        rd;
    logic        rs;
    logic [15:0] data;
  } fifo_entry_t;

  function automatic logic [31:0] pack_status(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic       rd_valid,
    input logic       overflow,
    input logic [7:0] level
  );
    return {16'h0000, level, 3'b000, overflow, rd_valid, empty, full, busy};
  endfunction

endpackage

// File: rtl/soc_system_lcd_cmd_fifo.sv
// -----------------------------------------------------------------------------
// soc_system_lcd_cmd_fifo
// Synchronous FIFO of LCD bus transactions.
// Ports:
//   clk, reset         - clock, synchronous active-high reset (flushes)
//   push_i/push_data_i - enqueue request and entry
//   pop_i/pop_data_o   - dequeue request; pop_data_o shows the head entry
//   full_o, empty_o    - occupancy flags
//   level_o            - number of stored entries
// A pop on empty is ignored; a push on full is ignored unless a pop happens
// in the same cycle, in which case both take effect.
// -----------------------------------------------------------------------------
module soc_system_lcd_cmd_fifo
  import soc_system_lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  fifo_entry_t                 push_data_i,
  input  logic                        pop_i,
  output fifo_entry_t                 pop_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  fifo_entry_t      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == LVL_W'(FIFO_DEPTH));
  assign do_pop_s   = pop_i & ~empty_o;
  assign do_push_s  = push_i & (~full_o | do_pop_s);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = count_q;

  // Entry storage; validity is tracked by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/soc_system_lcd_bus_ctrl.sv
// -----------------------------------------------------------------------------
// soc_system_lcd_bus_ctrl
// Avalon-MM slave that queues LCD write/command/read transactions and plays
// them out on an 8080-style parallel bus with programmable setup, strobe and
// hold phases.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   address, chipselect,
//   write_n, read_n, writedata - Avalon-MM slave request
//   readdata                   - registered read data (1-cycle latency)
//   lcd_data_out/lcd_data_oe   - bus drive value and tri-state enable
//   lcd_data_in                - bus sample value
//   lcd_rs, lcd_cs_n,
//   lcd_wr_n, lcd_rd_n         - LCD control lines
//   irq                        - only with SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN
// Build option: define SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN to add the irq output
// and the IRQ enable register at offset 5.
// -----------------------------------------------------------------------------
module soc_system_lcd_bus_ctrl
  import soc_system_lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] lcd_data_out,
  output logic        lcd_data_oe,
  input  logic [15:0] lcd_data_in,
  output logic        lcd_rs,
  output logic        lcd_cs_n,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n
`ifdef SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_en_s;
  logic             rd_en_s;
  logic             push_s;
  fifo_entry_t      push_entry_s;
  logic             pop_s;
  fifo_entry_t      head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic             capture_s;
  logic             unused_wdata_s;

  lcd_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  fifo_entry_t entry_q, entry_d;
  lcd_timing_t tlat_q, tlat_d;
  lcd_timing_t timing_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic        overflow_q;
  logic [31:0] readdata_q, readdata_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        rs_q, rs_d;
  logic        cs_n_q, cs_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;

  assign wr_en_s        = chipselect & ~write_n;
  assign rd_en_s        = chipselect & ~read_n;
  assign unused_wdata_s = ^writedata[31:16];

  // Strobe phase ends this cycle: the bus value is sampled at this edge.
  assign capture_s = (state_q == ST_STROBE) && (cnt_q == 4'd0) && entry_q.rd;

  // Decode register writes into FIFO pushes.
  always_comb begin
    push_s       = 1'b0;
    push_entry_s = '0;
    if (wr_en_s) begin
      case (address)
        ADDR_DATA: begin
          push_s       = 1'b1;
          push_entry_s = '{rd: 1'b0, rs: 1'b1, data: writedata[15:0]};
        end
        ADDR_CMD: begin
          push_s       = 1'b1;
          push_entry_s = '{rd: 1'b0, rs: 1'b0, data: writedata[15:0]};
        end
        ADDR_RDREQ: begin
          push_s       = 1'b1;
          push_entry_s = '{rd: 1'b1, rs: writedata[0], data: 16'h0000};
        end
        default: begin
          push_s       = 1'b0;
          push_entry_s = '0;
        end
      endcase
    end else begin
      push_s       = 1'b0;
      push_entry_s = '0;
    end
  end

  soc_system_lcd_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .level_o     (fifo_level_s)
  );

  // FSM next state: each phase counts down from its field value to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = timing_q.t_su;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = tlat_q.t_pw;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = tlat_q.t_h;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!fifo_empty_s) begin
          // Chain straight into the next transaction with no idle cycle.
          pop_s   = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = timing_q.t_su;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Latch the popped entry and the timing in force at pop time.
  always_comb begin
    if (pop_s) begin
      entry_d = head_s;
      tlat_d  = timing_q;
    end else begin
      entry_d = entry_q;
      tlat_d  = tlat_q;
    end
  end

  // Bus outputs from next state so the registered pins line up with the FSM.
  always_comb begin
    cs_n_d = 1'b1;
    rs_d   = 1'b0;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    oe_d   = 1'b0;
    dout_d = 16'h0000;
    if (state_d != ST_IDLE) begin
      cs_n_d = 1'b0;
      rs_d   = entry_d.rs;
      oe_d   = ~entry_d.rd;
      dout_d = entry_d.rd ? 16'h0000 : entry_d.data;
      if (state_d == ST_STROBE) begin
        wr_n_d = entry_d.rd;
        rd_n_d = ~entry_d.rd;
      end else begin
        wr_n_d = 1'b1;
        rd_n_d = 1'b1;
      end
    end else begin
      cs_n_d = 1'b1;
    end
  end

  // FSM state, latched transaction and registered bus pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      entry_q <= '0;
      tlat_q  <= TIMING_RESET;
      cs_n_q  <= 1'b1;
      rs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      tlat_q  <= tlat_d;
      cs_n_q  <= cs_n_d;
      rs_q    <= rs_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
    end
  end

  // Software-visible registers: TIMING, overflow flag, read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      timing_q   <= TIMING_RESET;
      overflow_q <= 1'b0;
      rd_data_q  <= 16'h0000;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en_s && (address == ADDR_TIMING)) begin
        timing_q <= writedata[11:0];
      end
      // A dropped push wins over a simultaneous clear.
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_q <= 1'b1;
      end else if (wr_en_s && (address == ADDR_STATUS) && writedata[4]) begin
        overflow_q <= 1'b0;
      end
      if (capture_s) begin
        rd_data_q  <= lcd_data_in;
        rd_valid_q <= 1'b1;
      end else if (rd_en_s && (address == ADDR_DATA)) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

`ifdef SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN
  logic [1:0] irq_en_q;
  logic       irq_q;

  // IRQ enables and registered interrupt line.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en_s && (address == ADDR_IRQ)) begin
        irq_en_q <= writedata[1:0];
      end
      irq_q <= (irq_en_q[0] & fifo_empty_s & (state_q == ST_IDLE)) |
               (irq_en_q[1] & rd_valid_q);
    end
  end

  assign irq = irq_q;
`endif

  // Read data mux, evaluated every cycle.
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (address)
      ADDR_DATA:   readdata_d = {16'h0000, rd_data_q};
      ADDR_STATUS: readdata_d = pack_status((state_q != ST_IDLE) | ~fifo_empty_s,
                                            fifo_full_s, fifo_empty_s, rd_valid_q,
                                            overflow_q, 8'(fifo_level_s));
      ADDR_TIMING: readdata_d = {20'h00000, timing_q};
`ifdef SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN
      ADDR_IRQ:    readdata_d = {30'h0, irq_en_q};
`endif
      default:     readdata_d = 32'h0000_0000;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 32'h0000_0000;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign lcd_data_out = dout_q;
  assign lcd_data_oe  = oe_q;
  assign lcd_rs       = rs_q;
  assign lcd_cs_n     = cs_n_q;
  assign lcd_wr_n     = wr_n_q;
  assign lcd_rd_n     = rd_n_q;

endmodule

// File: tb/tb_soc_system_lcd_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_soc_system_lcd_bus_ctrl
// Directed bench for the LCD bus controller: a table of per-cycle input /
// expected-output records, plus hand-written overflow and IRQ sequences.
// Bus control vector layout: {cs_n, rs, wr_n, rd_n, oe}.
// -----------------------------------------------------------------------------
module tb_soc_system_lcd_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] lcd_data_out;
  logic        lcd_data_oe;
  logic [15:0] lcd_data_in;
  logic        lcd_rs;
  logic        lcd_cs_n;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
`ifdef SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN
  logic        irq;
`endif

  soc_system_lcd_bus_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .read_n       (read_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .lcd_data_in  (lcd_data_in),
    .lcd_rs       (lcd_rs),
    .lcd_cs_n     (lcd_cs_n),
    .lcd_wr_n     (lcd_wr_n),
    .lcd_rd_n     (lcd_rd_n)
`ifdef SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] C_IDLE = 5'b10110;
  localparam logic [4:0] C_WS0  = 5'b00111;  // write setup/hold, rs=0
  localparam logic [4:0] C_WT0  = 5'b00011;  // write strobe, rs=0
  localparam logic [4:0] C_WS1  = 5'b01111;
  localparam logic [4:0] C_WT1  = 5'b01011;
  localparam logic [4:0] C_RS1  = 5'b01110;  // read setup/hold, rs=1
  localparam logic [4:0] C_RT1  = 5'b01100;  // read strobe, rs=1

  typedef struct {
    logic        rst;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [15:0] din;
    logic [4:0]  ctl;
    logic [15:0] dout;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, cs, wr, rd, input logic [2:0] a,
                     input logic [31:0] wd, input logic [15:0] din,
                     input logic [4:0] ctl, input logic [15:0] dout,
                     input logic chk_rd, input logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.cs = cs; v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd;
    v.din = din; v.ctl = ctl; v.dout = dout; v.chk_rd = chk_rd; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic v_w(input logic [2:0] a, input logic [31:0] wd,
                     input logic [4:0] ctl, input logic [15:0] dout);
    add(1'b0, 1'b1, 1'b1, 1'b0, a, wd, 16'h1111, ctl, dout, 1'b0, 32'h0);
  endtask

  task automatic v_r(input logic [2:0] a, input logic [4:0] ctl,
                     input logic [15:0] dout, input logic [31:0] rdata);
    add(1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0, 16'h1111, ctl, dout, 1'b1, rdata);
  endtask

  task automatic v_i(input logic [15:0] din, input logic [4:0] ctl, input logic [15:0] dout);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 32'h0, din, ctl, dout, 1'b0, 32'h0);
  endtask

  task automatic v_rst();
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 32'h0, 16'h1111, C_IDLE, 16'h0, 1'b1, 32'h0);
  endtask

  task automatic idle_in();
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; address = 3'd7; writedata = 32'h0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = wd;
    tick();
    idle_in();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] rd);
    chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0; address = a; writedata = 32'h0;
    tick();
    rd = readdata;
    idle_in();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [15:0] tx_data [16];
    int          tx_len  [16];
    int          n_tx;
    logic        prev_wr;
    logic        done;

    reset = 1'b1;
    lcd_data_in = 16'h1111;
    idle_in();

    // Reset state and register access.
    v_rst();
    v_rst();
    v_r(3'd4, C_IDLE, 16'h0, 32'h121);
    v_r(3'd3, C_IDLE, 16'h0, 32'h4);
    v_r(3'd5, C_IDLE, 16'h0, 32'h0);
    v_r(3'd6, C_IDLE, 16'h0, 32'h0);
    v_r(3'd7, C_IDLE, 16'h0, 32'h0);
    v_w(3'd6, 32'hFFFF, C_IDLE, 16'h0);
    v_r(3'd6, C_IDLE, 16'h0, 32'h0);
    v_w(3'd4, 32'hFFFF_F345, C_IDLE, 16'h0);
    v_r(3'd4, C_IDLE, 16'h0, 32'h345);
    v_w(3'd4, 32'h121, C_IDLE, 16'h0);
    v_r(3'd4, C_IDLE, 16'h0, 32'h121);
    v_r(3'd0, C_IDLE, 16'h0, 32'h0);
    // CMD 0x002C with default timing: SETUP 2, STROBE 3, HOLD 2.
    v_w(3'd1, 32'h002C, C_IDLE, 16'h0);
    v_i(16'h1111, C_WS0, 16'h002C);
    v_i(16'h1111, C_WS0, 16'h002C);
    v_i(16'h1111, C_WT0, 16'h002C);
    v_r(3'd3, C_WT0, 16'h002C, 32'h5);
    v_i(16'h1111, C_WT0, 16'h002C);
    v_i(16'h1111, C_WS0, 16'h002C);
    v_i(16'h1111, C_WS0, 16'h002C);
    v_i(16'h1111, C_IDLE, 16'h0);
    v_r(3'd3, C_IDLE, 16'h0, 32'h4);
    // TIMING 0: two back-to-back 3-cycle DATA transactions.
    v_w(3'd4, 32'h0, C_IDLE, 16'h0);
    v_w(3'd0, 32'h1234, C_IDLE, 16'h0);
    v_w(3'd0, 32'hABCD, C_WS1, 16'h1234);
    v_i(16'h1111, C_WT1, 16'h1234);
    v_i(16'h1111, C_WS1, 16'h1234);
    v_i(16'h1111, C_WS1, 16'hABCD);
    v_i(16'h1111, C_WT1, 16'hABCD);
    v_i(16'h1111, C_WS1, 16'hABCD);
    v_i(16'h1111, C_IDLE, 16'h0);
    v_w(3'd4, 32'h121, C_IDLE, 16'h0);
    // RDREQ rs=1: bus value present only during the last STROBE cycle.
    v_w(3'd2, 32'h1, C_IDLE, 16'h0);
    v_i(16'h1111, C_RS1, 16'h0);
    v_i(16'h1111, C_RS1, 16'h0);
    v_i(16'h1111, C_RT1, 16'h0);
    v_i(16'h1111, C_RT1, 16'h0);
    v_i(16'h1111, C_RT1, 16'h0);
    v_i(16'h5A5A, C_RS1, 16'h0);
    v_i(16'h1111, C_RS1, 16'h0);
    v_i(16'h1111, C_IDLE, 16'h0);
    v_r(3'd3, C_IDLE, 16'h0, 32'hC);
    v_r(3'd0, C_IDLE, 16'h0, 32'h5A5A);
    v_r(3'd3, C_IDLE, 16'h0, 32'h4);
    // Reset during STROBE with three entries queued.
    v_w(3'd1, 32'h11, C_IDLE, 16'h0);
    v_w(3'd1, 32'h22, C_WS0, 16'h0011);
    v_w(3'd1, 32'h33, C_WS0, 16'h0011);
    v_w(3'd1, 32'h44, C_WT0, 16'h0011);
    v_rst();
    v_r(3'd3, C_IDLE, 16'h0, 32'h4);
    v_r(3'd0, C_IDLE, 16'h0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      v_i(16'h1111, C_IDLE, 16'h0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      reset       = vecs[i].rst;
      chipselect  = vecs[i].cs;
      write_n     = ~vecs[i].wr;
      read_n      = ~vecs[i].rd;
      address     = vecs[i].addr;
      writedata   = vecs[i].wdata;
      lcd_data_in = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_ctl", i),
          {27'h0, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe}, {27'h0, vecs[i].ctl});
      chk($sformatf("vec%0d_dout", i), {16'h0, lcd_data_out}, {16'h0, vecs[i].dout});
      if (vecs[i].chk_rd) begin
        chk($sformatf("vec%0d_rdata", i), readdata, vecs[i].rdata);
      end
    end
    reset = 1'b0;
    idle_in();
    lcd_data_in = 16'h1111;

    // Overflow: slow first transaction, then FIFO_DEPTH+2 pushes.
    bus_write(3'd4, 32'hFFF);
    bus_write(3'd1, 32'hA0);
    for (int k = 1; k <= 10; k++) begin
      bus_write(3'd1, k);
    end
    bus_read(3'd3, r);
    chk("ovf_status", r, 32'h813);
    bus_write(3'd3, 32'h10);
    bus_read(3'd3, r);
    chk("ovf_cleared", r, 32'h803);
    bus_write(3'd4, 32'h0);
    n_tx = 0;
    prev_wr = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      if (!lcd_wr_n) begin
        if (prev_wr && n_tx < 16) begin
          tx_data[n_tx] = lcd_data_out;
          tx_len[n_tx] = 0;
          n_tx++;
        end
        if (n_tx > 0) tx_len[n_tx-1]++;
      end
      prev_wr = lcd_wr_n;
      if (n_tx > 0 && lcd_cs_n) done = 1'b1;
    end
    chk("ovf_drain_done", {31'h0, done}, 32'h1);
    chk("ovf_tx_count", n_tx, 32'd9);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("ovf_tx%0d_data", k), {16'h0, tx_data[k]}, (k == 0) ? 32'hA0 : k);
      chk($sformatf("ovf_tx%0d_strobe", k), tx_len[k], (k == 0) ? 32'd16 : 32'd1);
    end
    bus_read(3'd3, r);
    chk("ovf_final_status", r, 32'h4);
    bus_write(3'd4, 32'h121);

`ifdef SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN
    // IRQ on rd_valid: rises one cycle after capture, falls after DATA read.
    chk("irq_idle", {31'h0, irq}, 32'h0);
    bus_write(3'd5, 32'h2);
    bus_read(3'd5, r);
    chk("irq_reg", r, 32'h2);
    lcd_data_in = 16'h5A5A;
    bus_write(3'd2, 32'h1);
    for (int k = 0; k < 5; k++) tick();
    chk("irq_before_capture", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_at_capture", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_raised", {31'h0, irq}, 32'h1);
    tick();
    tick();
    bus_read(3'd0, r);
    chk("irq_data", r, 32'h5A5A);
    chk("irq_still_high", {31'h0, irq}, 32'h1);
    tick();
    chk("irq_fallen", {31'h0, irq}, 32'h0);
    bus_write(3'd5, 32'h1);
    tick();
    chk("irq_empty_ie", {31'h0, irq}, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/soc_system_lcd_bus_ctrl.md
# soc_system_lcd_bus_ctrl

Avalon-MM slave that sequences an 8080-style parallel LCD bus (16-bit data, RS, WR_n, RD_n, CS_n) from a queue of write, command and read transactions. It replaces software bit-banging of the LCD data PIO and control lines: the HPS pushes transactions into a command FIFO, and a timing state machine drives the bus with programmable setup, strobe and hold phases. It sits in soc_system beside the other PIO slaves on the lightweight bridge.

## Interface
- FIFO_DEPTH, 8 — command FIFO entries; power of 2, minimum 2.
- clk  in  1  — system clock; all logic is on its rising edge.
- reset  in  1  — synchronous, active-high.
- address  in  3  — word offset.
- chipselect  in  1  — slave select.
- write_n  in  1  — active-low write strobe.
- read_n  in  1  — active-low read strobe; used only for read side effects.
- writedata  in  32  — write data.
- readdata  out  32  — registered read data.
- lcd_data_out  out  16  — bus drive value.
- lcd_data_oe  out  1  — tri-state enable for lcd_data_out.
- lcd_data_in  in  16  — bus sample value.
- lcd_rs, lcd_cs_n, lcd_wr_n, lcd_rd_n  out  1 each — LCD control lines.

## Operation
- Register map (offset: function):
  - 0 DATA — W pushes write {rd=0, rs=1, data=writedata[15:0]}; R returns rd_data and clears rd_valid.
  - 1 CMD — W pushes write {rd=0, rs=0, data}.
  - 2 RDREQ — W pushes read {rd=1, rs=writedata[0], data=0}.
  - 3 STATUS — R bits: [0] busy (FSM≠IDLE or FIFO non-empty), [1] full, [2] empty, [3] rd_valid, [4] overflow, [15:8] level. W with writedata[4]=1 clears overflow.
  - 4 TIMING — R/W [3:0] T_SU, [7:4] T_PW, [11:8] T_H; reset value 0x121.
  - Other offsets read 0; writes to them are ignored.
- Push condition: chipselect & ~write_n. A push to a full FIFO is dropped and sets overflow, which stays set until cleared by software.
- FSM states and transitions:
  - IDLE: if FIFO is non-empty, pop the entry, latch it and the TIMING fields, then go to SETUP.
  - SETUP: lasts T_SU+1 cycles, then STROBE.
  - STROBE: lasts T_PW+1 cycles, then HOLD.
  - HOLD: lasts T_H+1 cycles. On the last HOLD cycle, if the FIFO is non-empty, pop and go directly to SETUP. Otherwise go to IDLE.
- Bus outputs:
  - lcd_cs_n=0 in SETUP, STROBE and HOLD.
  - lcd_rs = latched rs in those states; 0 in IDLE.
  - lcd_wr_n=0 in STROBE for writes.
  - lcd_rd_n=0 in STROBE for reads.
  - lcd_data_oe=1 and lcd_data_out = latched data in SETUP through HOLD for writes.
  - All outputs are registered.
- Read capture: lcd_data_in is sampled into rd_data at the clock edge that ends the last STROBE cycle, and rd_valid is set. A new capture overwrites rd_data.
- Phase-length arithmetic uses a 4-bit down-counter loaded with the field value. A field of 0 gives a 1-cycle phase and 15 gives 16 cycles; there is no wrap.
- A TIMING write during a transaction affects only subsequent transactions.
- Same-cycle push and pop: both take effect and the level is unchanged. A push into a full FIFO in the same cycle as a pop is accepted.
- A DATA read in the same cycle as a capture leaves rd_valid set.

## Timing
- Reset values:
  - readdata=0, lcd_data_out=0, lcd_data_oe=0, lcd_rs=0.
  - lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1.
  - FIFO empty, FSM IDLE, rd_data=0, rd_valid=0, overflow=0, TIMING=0x121.
- Reset mid-transaction: outputs return to their reset values at the next edge and the FIFO is flushed.
- Read latency is 1 cycle. readdata <= mux(address) every cycle, with no waitrequest.
- Latency from push into an empty idle FIFO to lcd_cs_n falling: 2 cycles (push edge, then pop edge).
- Default transaction length is 7 bus cycles (SETUP 2, STROBE 3, HOLD 2). Back-to-back transactions have 0 idle cycles between HOLD and SETUP.

## Configuration
- SOC_SYSTEM_LCD_BUS_CTRL_IRQ_EN defined:
  - Adds an `irq` output (1 bit) and an IRQ register at offset 5: [0] empty_ie, [1] rdvalid_ie; R/W; reset 0.
  - irq = (empty_ie & empty & FSM IDLE) | (rdvalid_ie & rd_valid), registered.
- Undefined: no irq port; offset 5 reads 0.

## Structure
- Package soc_system_lcd_pkg holds:
  - the FSM state enum;
  - register offset constants;
  - the TIMING reset constant 0x121;
  - the FIFO entry struct {rd, rs, data[15:0]} (18 bits).
- Sub-module soc_system_lcd_cmd_fifo: synchronous FIFO, parameter FIFO_DEPTH, with push, pop, full, empty and level outputs. Pop on empty and push on full (without a simultaneous pop) are ignored inside the FIFO.

## Test plan
- Reset, then write CMD 0x002C: cs_n falls 2 cycles later, rs=0, wr_n is low for 3 cycles, and the bus is held at 0x002C with oe=1 for 7 cycles. STATUS then reads 0x0004.
- Write TIMING 0x000, then DATA 0x1234 and DATA 0xABCD back-to-back: two 3-cycle transactions with no idle gap and rs=1 throughout.
- Write RDREQ 1 with lcd_data_in=0x5A5A during STROBE: STATUS[3]=1, DATA reads 0x5A5A, and the next STATUS read shows [3]=0.
- Issue FIFO_DEPTH+2 pushes while the bus is busy with TIMING 0xFFF: exactly the overflowing pushes are dropped, STATUS[4]=1, and writing STATUS 0x10 clears it.
- Assert reset during STROBE of a write with 3 entries queued: the next edge shows cs_n=1, wr_n=1, oe=0 and STATUS empty, and no further bus activity occurs.
- With the IRQ macro, set IRQ=0x2 and issue RDREQ: irq rises one cycle after rd_valid sets and falls after a DATA read.
